// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue controller: funct codes, FSM states,
// and default datapath width.
package alu_pkg;

    localparam int DATA_W_DEF = 32;

    localparam logic [3:0] ADD       = 4'd0;
    localparam logic [3:0] SUB       = 4'd1;
    localparam logic [3:0] AND       = 4'd2;
    localparam logic [3:0] OR        = 4'd3;
    localparam logic [3:0] XOR       = 4'd4;
    localparam logic [3:0] NOT       = 4'd5;
    localparam logic [3:0] SLA       = 4'd6;
    localparam logic [3:0] SRA       = 4'd7;
    localparam logic [3:0] SRL       = 4'd8;
    localparam logic [3:0] FUNCT_MAX = 4'd8;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

endpackage

// File: rtl/alu_cmd_fifo.sv
// Two-entry command FIFO; a push into a full FIFO is taken only when a pop
// frees a slot in the same cycle.
module alu_cmd_fifo #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic [1:0]       count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == 2'd2);
    assign empty   = (count == 2'd0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) wr_ptr <= ~wr_ptr;
            if (do_pop)  rd_ptr <= ~rd_ptr;
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issues commands to an external registered ALU and returns its result.
// Optional ALU_CMD_FIFO_EN adds a 2-entry command FIFO ahead of the FSM.
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int ALU_LAT = 1,
    parameter int DATA_W  = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [3:0]        cmd_funct,
    input  logic [DATA_W-1:0] cmd_a,
    input  logic [DATA_W-1:0] cmd_b,
    input  logic [4:0]        cmd_shamt,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [4:0]        alu_shamt,
    output logic [3:0]        alu_funct,
    input  logic [DATA_W-1:0] alu_res,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_res,
    output logic              rsp_err,
    output logic              busy
);

    state_t            state;
    state_t            state_nxt;
    logic [3:0]        cnt;
    logic              req_valid;
    logic [3:0]        req_funct;
    logic [DATA_W-1:0] req_a;
    logic [DATA_W-1:0] req_b;
    logic [4:0]        req_shamt;
    logic              take;
    logic              legal;

`ifdef ALU_CMD_FIFO_EN
    localparam int FW = 4 + 2 * DATA_W + 5;

    logic          fifo_full;
    logic          fifo_empty;
    logic [FW-1:0] fifo_dout;

    assign cmd_ready = rst_n && !fifo_full;

    alu_cmd_fifo #(
        .WIDTH(FW)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (cmd_valid && cmd_ready),
        .din   ({cmd_funct, cmd_a, cmd_b, cmd_shamt}),
        .pop   (take),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign req_valid = !fifo_empty;
    assign {req_funct, req_a, req_b, req_shamt} = fifo_dout;
`else
    assign cmd_ready = rst_n && (state == IDLE);
    assign req_valid = cmd_valid && cmd_ready;
    assign req_funct = cmd_funct;
    assign req_a     = cmd_a;
    assign req_b     = cmd_b;
    assign req_shamt = cmd_shamt;
`endif

    assign take  = (state == IDLE) && req_valid;
    assign legal = (req_funct <= FUNCT_MAX);

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (take) state_nxt = legal ? EXEC : RESP;
            EXEC:    if (cnt == 4'd0) state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        rsp_valid = (state == RESP);
        busy      = (state != IDLE);
    end

    // alu_* are only written on a legal accept so the ALU output stays put
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            alu_a     <= '0;
            alu_b     <= '0;
            alu_shamt <= '0;
            alu_funct <= '0;
            cnt       <= '0;
            rsp_res   <= '0;
            rsp_err   <= 1'b0;
        end else begin
            if (take && legal) begin
                alu_a     <= req_a;
                alu_b     <= req_b;
                alu_shamt <= req_shamt;
                alu_funct <= req_funct;
                cnt       <= 4'(ALU_LAT);
            end
            if (take && !legal) begin
                rsp_res <= '0;
                rsp_err <= 1'b1;
            end
            if (state == EXEC) begin
                if (cnt != 4'd0) begin
                    cnt <= cnt - 4'd1;
                end else begin
                    rsp_res <= alu_res;
                    rsp_err <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Scoreboard bench for alu_issue_ctrl with a behavioural registered ALU.
// Define ALU_CMD_FIFO_EN to run the FIFO ordering scenario instead.
module tb_alu_issue_ctrl;
    import alu_pkg::*;

    localparam int ALU_LAT = 1;
    localparam int DATA_W  = 32;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [3:0]        cmd_funct;
    logic [DATA_W-1:0] cmd_a;
    logic [DATA_W-1:0] cmd_b;
    logic [4:0]        cmd_shamt;
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [4:0]        alu_shamt;
    logic [3:0]        alu_funct;
    logic [DATA_W-1:0] alu_res;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_res;
    logic              rsp_err;
    logic              busy;

    alu_issue_ctrl #(
        .ALU_LAT(ALU_LAT),
        .DATA_W (DATA_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_funct (cmd_funct),
        .cmd_a     (cmd_a),
        .cmd_b     (cmd_b),
        .cmd_shamt (cmd_shamt),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_shamt (alu_shamt),
        .alu_funct (alu_funct),
        .alu_res   (alu_res),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_res   (rsp_res),
        .rsp_err   (rsp_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] alu_fn(
        input logic [3:0] f, input logic [31:0] a,
        input logic [31:0] b, input logic [4:0] sh);
        logic [4:0] s;
        s = (sh == 5'd0) ? {4'd0, b[0]} : sh;
        case (f)
            ADD:     return a + b;
            SUB:     return a - b;
            AND:     return a & b;
            OR:      return a | b;
            XOR:     return a ^ b;
            NOT:     return ~a;
            SLA:     return a << s;
            SRA:     return $unsigned($signed(a) >>> s);
            SRL:     return a >> s;
            default: return 32'd0;
        endcase
    endfunction

    always @(posedge clk) alu_res <= alu_fn(alu_funct, alu_a, alu_b, alu_shamt);

    typedef struct {
        logic [31:0] res;
        logic        err;
        int          acc;
        int          lat;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;
    int   first = 0;
    bit   prev = 1'b0;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    // monitor: latency measured from accept cycle to first rsp_valid cycle
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            prev = 1'b0;
        end else begin
            if (rsp_valid && !prev) first = cyc;
            prev = rsp_valid;
            if (rsp_valid && rsp_ready) begin
                if (q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_rsp: got res %h, none expected",
                             rsp_res);
                end else begin
                    e = q.pop_front();
                    chk("rsp_res", rsp_res, e.res);
                    chk("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
                    chk("latency", first - e.acc, e.lat);
                end
            end
        end
    end

    task automatic send(input logic [3:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] sh,
                        input logic [31:0] er, input logic ee,
                        input int lat, input bit want, output int acc);
        exp_t e;
        bit   done;
        done      = 1'b0;
        acc       = -1;
        cmd_valid = 1'b1;
        cmd_funct = f;
        cmd_a     = a;
        cmd_b     = b;
        cmd_shamt = sh;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (cmd_ready) begin
                done = 1'b1;
                acc  = cyc;
                if (want) begin
                    e.res = er;
                    e.err = ee;
                    e.acc = cyc;
                    e.lat = lat;
                    q.push_back(e);
                end
            end
        end
        if (!done) begin
            vectors++;
            miscompares++;
            $display("FAIL accept_timeout: got no cmd_ready, required 1");
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic drain(input int budget);
        int i;
        for (i = 0; i < budget && q.size() != 0; i++) @(negedge clk);
        if (q.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL drain_timeout: got %0d pending, required 0",
                     q.size());
            q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    int  acc0;
    int  acc1;
    int  acc2;
    int  hs;
    bit  seen;

    initial begin
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_funct = '0;
        cmd_a     = '0;
        cmd_b     = '0;
        cmd_shamt = '0;
        rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("ready_in_reset", {31'd0, cmd_ready}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rsp_res", rsp_res, 32'd0);
        chk("rst_alu_a", alu_a, 32'd0);
        chk("rst_alu_funct", {28'd0, alu_funct}, 32'd0);
        @(posedge clk);
        #1;

`ifdef ALU_CMD_FIFO_EN
        send(ADD, 32'd1, 32'd1, 5'd0, 32'd2, 1'b0, 4, 1'b1, acc0);
        send(OR, 32'hF0, 32'h0F, 5'd0, 32'hFF, 1'b0, 7, 1'b1, acc1);
        send(XOR, 32'hFF, 32'h0F, 5'd0, 32'hF0, 1'b0, 10, 1'b1, acc2);
        @(negedge clk);
        chk("fifo_full_ready", {31'd0, cmd_ready}, 32'd0);
        chk("b2b_accept_1", acc1 - acc0, 32'd1);
        chk("b2b_accept_2", acc2 - acc0, 32'd2);
        drain(60);
`else
        send(ADD, 32'd5, 32'd7, 5'd0, 32'h0000000C, 1'b0, 3, 1'b1, acc0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("cmd_ready_busy", {31'd0, cmd_ready}, 32'd0);
        end
        drain(20);
        send(SUB, 32'd3, 32'd5, 5'd0, 32'hFFFFFFFE, 1'b0, 3, 1'b1, acc0);
        drain(20);
        send(SRA, 32'h80000000, 32'd0, 5'd4, 32'hF8000000, 1'b0, 3, 1'b1,
             acc0);
        drain(20);
        send(SRL, 32'h80000000, 32'd0, 5'd4, 32'h08000000, 1'b0, 3, 1'b1,
             acc0);
        drain(20);
        send(NOT, 32'h0F0F0F0F, 32'hFFFF, 5'd0, 32'hF0F0F0F0, 1'b0, 3, 1'b1,
             acc0);
        drain(20);
        send(SLA, 32'd1, 32'd1, 5'd0, 32'h00000002, 1'b0, 3, 1'b1, acc0);
        drain(20);

        send(4'hC, 32'h1234, 32'd0, 5'd0, 32'd0, 1'b1, 1, 1'b1, acc0);
        drain(20);
        chk("illegal_alu_funct", {28'd0, alu_funct}, {28'd0, SLA});
        chk("illegal_alu_a", alu_a, 32'd1);

        // back-pressure with a second command held on the request port
        rsp_ready = 1'b0;
        send(ADD, 32'd10, 32'd20, 5'd0, 32'd30, 1'b0, 3, 1'b1, acc0);
        hs = -1;
        fork
            send(AND, 32'hF0F0, 32'hFF00, 5'd0, 32'hF000, 1'b0, 3, 1'b1,
                 acc1);
            begin
                for (int i = 0; i < 20 && !rsp_valid; i++) @(negedge clk);
                for (int k = 0; k < 5; k++) begin
                    chk("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
                    chk("bp_rsp_res", rsp_res, 32'd30);
                    chk("bp_cmd_ready", {31'd0, cmd_ready}, 32'd0);
                    @(negedge clk);
                end
                @(posedge clk);
                #1;
                rsp_ready = 1'b1;
                @(negedge clk);
                hs = cyc;
            end
        join
        chk("held_accept_cycle", acc1, hs + 1);
        drain(20);

        send(ADD, 32'd9, 32'd9, 5'd0, 32'd0, 1'b0, 0, 1'b0, acc0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("mid_rst_alu_a", alu_a, 32'd0);
        chk("mid_rst_alu_b", alu_b, 32'd0);
        chk("mid_rst_alu_funct", {28'd0, alu_funct}, 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (rsp_valid) seen = 1'b1;
        end
        chk("no_rsp_after_rst", {31'd0, seen}, 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
